// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO of preg indices, two allocs and two frees per cycle.
// Optional duplicate-free detection is built when FREELIST_DUPCHK_EN is defined.
module preg_free_list #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int PREG_W    = 7,
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req_1,
  input  logic              alloc_req_2,
  output logic              alloc_grant_1,
  output logic              alloc_grant_2,
  output logic [PREG_W-1:0] alloc_preg_1,
  output logic [PREG_W-1:0] alloc_preg_2,
  input  logic              free_vld_1,
  input  logic [PREG_W-1:0] free_preg_1,
  input  logic              free_vld_2,
  input  logic [PREG_W-1:0] free_preg_2,
  output logic [PREG_W:0]   free_count,
  output logic              empty,
  output logic              almost_empty,
`ifdef FREELIST_DUPCHK_EN
  output logic              dup_err,
`endif
  output logic              overflow_err
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0]   ptr_t;
  typedef logic [PREG_W:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam ptr_t LAST_C  = ptr_t'(DEPTH - 1);

  function automatic ptr_t nxt(input ptr_t p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  logic [PREG_W-1:0] fifo [DEPTH];
  ptr_t head;
  ptr_t tail;
  cnt_t count;

  ptr_t head_1;
  ptr_t head_n;
  ptr_t tail_1;
  ptr_t slot_2;
  ptr_t tail_n;
  cnt_t cnt_g;
  cnt_t cnt_1;
  logic dup_1;
  logic dup_2;
  logic live_1;
  logic live_2;
  logic acc_1;
  logic acc_2;

  assign head_1 = nxt(head);
  assign tail_1 = nxt(tail);

  assign alloc_preg_1 = fifo[head];
  assign alloc_preg_2 = alloc_req_1 ? fifo[head_1] : fifo[head];

  // Lane 2 needs two entries when lane 1 also asks, so an
  // empty-refused lane 1 also blocks lane 2.
  assign alloc_grant_1 = alloc_req_1 && (count >= cnt_t'(1));
  assign alloc_grant_2 = alloc_req_2 &&
    (count >= (alloc_req_1 ? cnt_t'(2) : cnt_t'(1)));

`ifdef FREELIST_DUPCHK_EN
  logic [NUM_PREGS-1:0] in_pool;

  assign dup_1 = in_pool[free_preg_1];
  assign dup_2 = in_pool[free_preg_2] ||
    (free_vld_1 && (free_preg_1 == free_preg_2));
`else
  assign dup_1 = 1'b0;
  assign dup_2 = 1'b0;
`endif

  assign live_1 = free_vld_1 && (free_preg_1 != '0) && !dup_1;
  assign live_2 = free_vld_2 && (free_preg_2 != '0) && !dup_2;

  // Capacity is judged after this cycle's grants have left the pool.
  assign cnt_g = count - cnt_t'(alloc_grant_1) - cnt_t'(alloc_grant_2);
  assign acc_1 = live_1 && (cnt_g < DEPTH_C);
  assign cnt_1 = cnt_g + cnt_t'(acc_1);
  assign acc_2 = live_2 && (cnt_1 < DEPTH_C);

  assign slot_2 = acc_1 ? tail_1 : tail;
  assign tail_n = acc_2 ? nxt(slot_2) : slot_2;

  always_comb begin
    head_n = head;
    unique case (1'b1)
      alloc_grant_1 && alloc_grant_2: head_n = nxt(head_1);
      alloc_grant_1 ^ alloc_grant_2:  head_n = head_1;
      default:                        head_n = head;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i] <= PREG_W'(NUM_AREGS + i);
      end
      head         <= '0;
      tail         <= '0;
      count        <= DEPTH_C;
      overflow_err <= 1'b0;
    end else begin
      if (acc_1) fifo[tail] <= free_preg_1;
      if (acc_2) fifo[slot_2] <= free_preg_2;
      head  <= head_n;
      tail  <= tail_n;
      count <= cnt_1 + cnt_t'(acc_2);
      if ((live_1 && !acc_1) || (live_2 && !acc_2)) begin
        overflow_err <= 1'b1;
      end
    end
  end

`ifdef FREELIST_DUPCHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        in_pool[i] <= (i >= NUM_AREGS);
      end
      dup_err <= 1'b0;
    end else begin
      if (alloc_grant_1) in_pool[alloc_preg_1] <= 1'b0;
      if (alloc_grant_2) in_pool[alloc_preg_2] <= 1'b0;
      if (acc_1) in_pool[free_preg_1] <= 1'b1;
      if (acc_2) in_pool[free_preg_2] <= 1'b1;
      if ((free_vld_1 && free_preg_1 != '0 && dup_1) ||
          (free_vld_2 && free_preg_2 != '0 && dup_2)) begin
        dup_err <= 1'b1;
      end
    end
  end
`endif

  assign free_count   = count;
  assign empty        = (count == '0);
  assign almost_empty = (count < cnt_t'(2));

endmodule
